// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: request/response and data-memory port bundle for stack_ctrl.
interface stack_ctrl_if #(parameter int ADDR_W = 10);
    logic              op_valid;
    logic              op_ready;
    logic [2:0]        op_code;
    logic [31:0]       op_wdata;
    logic [3:0]        op_flags;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [15:0]       mem_rdata;
    logic              done;
    logic [31:0]       rdata;
    logic [3:0]        rflags;
    logic [ADDR_W-1:0] sp;
    logic              err;
    modport master (
        output op_valid, op_code, op_wdata, op_flags, mem_rdata,
        input  op_ready, mem_addr, mem_wdata, mem_we, mem_re, done, rdata, rflags, sp, err
    );
    modport slave (
        input  op_valid, op_code, op_wdata, op_flags, mem_rdata,
        output op_ready, mem_addr, mem_wdata, mem_we, mem_re, done, rdata, rflags, sp, err
    );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: stack-pointer sequencer turning PUSH/POP/CALL/RET/INT/RTI into 16-bit memory word accesses.
// Define STACK_GUARD_EN to reject overflowing pushes and underflowing pops with err.
module stack_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input logic         clk,
    input logic         rst,
    stack_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FIN} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] sp_q;
    logic [1:0]        n_q, cnt, n, r;
    logic [2:0]        c1;
    logic [31:0]       pc, rdata_q;
    logic [3:0]        flags, rflags_q;
    logic [DATA_W-1:0] lo, hi;
    logic              err_q, is_push, is_pop, bad, last;
    always_comb begin
        c1 = bus.op_code + 3'd1;
        n = c1[2:1];
        is_push = bus.op_code inside {3'd1, 3'd3, 3'd5};
        is_pop = bus.op_code inside {3'd2, 3'd4, 3'd6};
`ifdef STACK_GUARD_EN
        bad = (is_push && sp_q < ADDR_W'(n)) || (is_pop && ~sp_q < ADDR_W'(n));
`else
        bad = 1'b0;
`endif
        last = cnt == n_q - 2'd1;
        // word index counted from the top of the frame: 0=PC lo, 1=PC hi, 2=flags
        r = n_q - 2'd1 - cnt;
        state_n = state;
        case (state)
            IDLE:    if (bus.op_valid) state_n = (bad || !(is_push || is_pop)) ? FIN : is_push ? WRITE : READ;
            WRITE:   state_n = last ? FIN : WRITE;
            READ:    state_n = last ? DRAIN : READ;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '1;
            n_q <= '0;
            cnt <= '0;
            pc <= '0;
            flags <= '0;
            lo <= '0;
            hi <= '0;
            rdata_q <= '0;
            rflags_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == IDLE && bus.op_valid) begin
                n_q <= n;
                cnt <= '0;
                pc <= bus.op_wdata;
                flags <= bus.op_flags;
                err_q <= bad;
            end
            if (state == WRITE) begin
                sp_q <= sp_q - ADDR_W'(1);
                cnt <= cnt + 2'd1;
            end
            // read data lags its issue by one cycle, so issue k captures word k-1
            if (state == READ) begin
                sp_q <= sp_q + ADDR_W'(1);
                cnt <= cnt + 2'd1;
                if (cnt == 2'd1) lo <= bus.mem_rdata;
                if (cnt == 2'd2) hi <= bus.mem_rdata;
            end
            if (state == DRAIN) begin
                rdata_q <= bus.rdata;
                rflags_q <= bus.rflags;
            end
        end
    end
    assign bus.op_ready = state == IDLE;
    assign bus.mem_we = state == WRITE;
    assign bus.mem_re = state == READ;
    assign bus.mem_addr = state == WRITE ? sp_q : state == READ ? sp_q + ADDR_W'(1) : '0;
    assign bus.mem_wdata = state != WRITE ? '0 : r == 2'd0 ? pc[15:0] : r == 2'd1 ? pc[31:16] : {12'h0, flags};
    assign bus.done = state == FIN || state == DRAIN;
    assign bus.err = state == FIN && err_q;
    // the last word is still on mem_rdata during DRAIN, so results are formed combinationally there
    assign bus.rdata = state != DRAIN ? rdata_q : n_q == 2'd1 ? {16'h0, bus.mem_rdata} :
                       n_q == 2'd2 ? {bus.mem_rdata, lo} : {hi, lo};
    assign bus.rflags = state == DRAIN && n_q == 2'd3 ? bus.mem_rdata[3:0] : rflags_q;
    assign bus.sp = sp_q;
endmodule
